// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared word and arbiter state types for the LC-3b memory path
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE,
        I_BUSY,
        D_BUSY,
        RESP
    } lc3b_arb_state;

endpackage

// File: rtl/arb_req_latch.sv
// rtl/arb_req_latch.sv - captures the granted request's address, data, lanes and direction
module arb_req_latch
    import lc3b_types::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  lc3b_word   addr_in,
    input  lc3b_word   wdata_in,
    input  logic [1:0] be_in,
    input  logic       we_in,
    output lc3b_word   addr_q,
    output lc3b_word   wdata_q,
    output logic [1:0] be_q,
    output logic       we_q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
        end else if (load) begin
            addr_q  <= addr_in;
            wdata_q <= wdata_in;
            be_q    <= be_in;
            we_q    <= we_in;
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - serializes split instruction/data requests onto one L2 port
module cpu_mem_arbiter
    import lc3b_types::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instruction_request,
    input  lc3b_word   instruction_address,
    output logic       instruction_response,
    output lc3b_word   instr,
    input  logic       data_request,
    input  logic       write_enable,
    input  lc3b_word   mem_address,
    input  logic [1:0] mem_byte_enable,
    input  lc3b_word   write_data,
    output logic       data_response,
    output lc3b_word   mem_rdata,
    output logic       l2_read,
    output logic       l2_write,
    output lc3b_word   l2_address,
    output lc3b_word   l2_wdata,
    output logic [1:0] l2_byte_enable,
    input  lc3b_word   l2_rdata,
    input  logic       l2_resp
);

    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    lc3b_arb_state state, next_state;
    logic [STREAK_W-1:0] streak;
    logic abort;
    logic src_instr;
    logic grant_d, grant_i;

    lc3b_word   lat_addr, lat_wdata;
    logic [1:0] lat_be;
    logic       lat_we;

    // Fetches always read the full word; only data grants carry real store fields.
    arb_req_latch u_req_latch (
        .clk      (clk),
        .reset    (reset),
        .load     (grant_d | grant_i),
        .addr_in  (grant_d ? mem_address : instruction_address),
        .wdata_in (grant_d ? write_data : '0),
        .be_in    (grant_d ? mem_byte_enable : 2'b11),
        .we_in    (grant_d & write_enable),
        .addr_q   (lat_addr),
        .wdata_q  (lat_wdata),
        .be_q     (lat_be),
        .we_q     (lat_we)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            streak    <= '0;
            abort     <= 1'b0;
            src_instr <= 1'b0;
            instr     <= '0;
            mem_rdata <= '0;
        end else begin
            state <= next_state;
            if (grant_d) begin
                src_instr <= 1'b0;
                abort     <= 1'b0;
                if (!instruction_request)
                    streak <= '0;
                else if (streak != STREAK_MAX)
                    streak <= streak + 1'b1;
            end else if (grant_i) begin
                src_instr <= 1'b1;
                abort     <= 1'b0;
                streak    <= '0;
            end
            // A flush anywhere during the fetch poisons its result.
            if (state == I_BUSY && !instruction_request)
                abort <= 1'b1;
            if (state == I_BUSY && l2_resp && !abort && instruction_request)
                instr <= l2_rdata;
            if (state == D_BUSY && l2_resp && !lat_we)
                mem_rdata <= l2_rdata;
        end
    end

    always_comb begin
        next_state           = state;
        grant_d              = 1'b0;
        grant_i              = 1'b0;
        l2_read              = 1'b0;
        l2_write             = 1'b0;
        l2_address           = '0;
        l2_wdata             = '0;
        l2_byte_enable       = '0;
        instruction_response = 1'b0;
        data_response        = 1'b0;
        case (state)
            IDLE: begin
                if (data_request && (!instruction_request || streak < STREAK_MAX)) begin
                    grant_d    = 1'b1;
                    next_state = D_BUSY;
                end else if (instruction_request) begin
                    grant_i    = 1'b1;
                    next_state = I_BUSY;
                end
            end
            I_BUSY: begin
                l2_read        = 1'b1;
                l2_address     = lat_addr;
                l2_byte_enable = 2'b11;
                if (l2_resp)
                    next_state = (!abort && instruction_request) ? RESP : IDLE;
            end
            D_BUSY: begin
                l2_write       = lat_we;
                l2_read        = ~lat_we;
                l2_address     = lat_addr;
                l2_wdata       = lat_wdata;
                l2_byte_enable = lat_be;
                if (l2_resp)
                    next_state = RESP;
            end
            RESP: begin
                instruction_response = src_instr;
                data_response        = ~src_instr;
                next_state           = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb/tb_cpu_mem_arbiter.sv - directed self-checking bench for cpu_mem_arbiter
module tb_cpu_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        instruction_request;
    logic [15:0] instruction_address;
    logic        instruction_response;
    logic [15:0] instr;
    logic        data_request;
    logic        write_enable;
    logic [15:0] mem_address;
    logic [1:0]  mem_byte_enable;
    logic [15:0] write_data;
    logic        data_response;
    logic [15:0] mem_rdata;
    logic        l2_read;
    logic        l2_write;
    logic [15:0] l2_address;
    logic [15:0] l2_wdata;
    logic [1:0]  l2_byte_enable;
    logic [15:0] l2_rdata;
    logic        l2_resp;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_mem_arbiter #(.MAX_DATA_STREAK(4)) dut (
        .clk                  (clk),
        .reset                (reset),
        .instruction_request  (instruction_request),
        .instruction_address  (instruction_address),
        .instruction_response (instruction_response),
        .instr                (instr),
        .data_request         (data_request),
        .write_enable         (write_enable),
        .mem_address          (mem_address),
        .mem_byte_enable      (mem_byte_enable),
        .write_data           (write_data),
        .data_response        (data_response),
        .mem_rdata            (mem_rdata),
        .l2_read              (l2_read),
        .l2_write             (l2_write),
        .l2_address           (l2_address),
        .l2_wdata             (l2_wdata),
        .l2_byte_enable       (l2_byte_enable),
        .l2_rdata             (l2_rdata),
        .l2_resp              (l2_resp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        instruction_request = 1'b0; instruction_address = '0;
        data_request = 1'b0; write_enable = 1'b0; mem_address = '0;
        mem_byte_enable = '0; write_data = '0;
        l2_rdata = '0; l2_resp = 1'b0;
        tick(); tick();
        chk("rst_l2_read", {15'd0, l2_read}, 16'd0);
        chk("rst_l2_write", {15'd0, l2_write}, 16'd0);
        chk("rst_l2_addr", l2_address, 16'h0000);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_mem_rdata", mem_rdata, 16'h0000);
        reset = 1'b0;
        tick();

        // Fetch only
        instruction_request = 1'b1; instruction_address = 16'h0040;
        tick();
        chk("f_l2_read", {15'd0, l2_read}, 16'd1);
        chk("f_l2_write", {15'd0, l2_write}, 16'd0);
        chk("f_l2_addr", l2_address, 16'h0040);
        chk("f_l2_be", {14'd0, l2_byte_enable}, 16'h0003);
        l2_resp = 1'b1; l2_rdata = 16'h1234;
        tick();
        chk("f_resp", {15'd0, instruction_response}, 16'd1);
        chk("f_instr", instr, 16'h1234);
        chk("f_no_dresp", {15'd0, data_response}, 16'd0);
        chk("f_read_drop", {15'd0, l2_read}, 16'd0);
        l2_resp = 1'b0; instruction_request = 1'b0;
        tick();
        chk("f_resp_once", {15'd0, instruction_response}, 16'd0);
        chk("f_instr_hold", instr, 16'h1234);

        // Store, with one wait cycle from downstream
        data_request = 1'b1; write_enable = 1'b1; mem_address = 16'h8000;
        write_data = 16'hBEEF; mem_byte_enable = 2'b01;
        tick();
        chk("s_l2_write", {15'd0, l2_write}, 16'd1);
        chk("s_l2_read", {15'd0, l2_read}, 16'd0);
        chk("s_l2_addr", l2_address, 16'h8000);
        chk("s_l2_wdata", l2_wdata, 16'hBEEF);
        chk("s_l2_be", {14'd0, l2_byte_enable}, 16'h0001);
        write_data = 16'h0000; mem_address = 16'h0000;
        tick();
        chk("s_stable_addr", l2_address, 16'h8000);
        chk("s_stable_wdata", l2_wdata, 16'hBEEF);
        chk("s_stable_write", {15'd0, l2_write}, 16'd1);
        l2_resp = 1'b1; l2_rdata = 16'hFFFF;
        tick();
        chk("s_dresp", {15'd0, data_response}, 16'd1);
        chk("s_no_iresp", {15'd0, instruction_response}, 16'd0);
        chk("s_rdata_untouched", mem_rdata, 16'h0000);
        l2_resp = 1'b0; data_request = 1'b0; write_enable = 1'b0;
        tick();
        chk("s_dresp_once", {15'd0, data_response}, 16'd0);

        // Simultaneous requests: data first, then instruction
        instruction_request = 1'b1; instruction_address = 16'h0010;
        data_request = 1'b1; mem_address = 16'h2000; mem_byte_enable = 2'b11;
        tick();
        chk("sim_d_read", {15'd0, l2_read}, 16'd1);
        chk("sim_d_addr", l2_address, 16'h2000);
        l2_resp = 1'b1; l2_rdata = 16'hAAAA;
        tick();
        chk("sim_dresp", {15'd0, data_response}, 16'd1);
        chk("sim_mem_rdata", mem_rdata, 16'hAAAA);
        chk("sim_no_iresp", {15'd0, instruction_response}, 16'd0);
        l2_resp = 1'b0; data_request = 1'b0;
        tick();
        chk("sim_idle_read", {15'd0, l2_read}, 16'd0);
        tick();
        chk("sim_i_addr", l2_address, 16'h0010);
        chk("sim_i_read", {15'd0, l2_read}, 16'd1);
        l2_resp = 1'b1; l2_rdata = 16'h5555;
        tick();
        chk("sim_iresp", {15'd0, instruction_response}, 16'd1);
        chk("sim_instr", instr, 16'h5555);
        chk("sim_mem_hold", mem_rdata, 16'hAAAA);
        l2_resp = 1'b0; instruction_request = 1'b0;
        tick();

        // Starvation: four data grants, then the instruction is forced
        instruction_request = 1'b1; instruction_address = 16'h0050;
        data_request = 1'b1; mem_address = 16'h3000; write_enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("stv_d%0d_addr", k), l2_address, 16'h3000);
            l2_resp = 1'b1; l2_rdata = 16'h0100 + 16'(k);
            tick();
            chk($sformatf("stv_d%0d_resp", k), {15'd0, data_response}, 16'd1);
            chk($sformatf("stv_d%0d_rdata", k), mem_rdata, 16'h0100 + 16'(k));
            l2_resp = 1'b0;
            tick();
        end
        tick();
        chk("stv_forced_addr", l2_address, 16'h0050);
        chk("stv_forced_read", {15'd0, l2_read}, 16'd1);
        l2_resp = 1'b1; l2_rdata = 16'h7777;
        tick();
        chk("stv_iresp", {15'd0, instruction_response}, 16'd1);
        chk("stv_instr", instr, 16'h7777);
        l2_resp = 1'b0; instruction_request = 1'b0;
        tick();
        tick();
        chk("stv_data_again", l2_address, 16'h3000);
        l2_resp = 1'b1; l2_rdata = 16'h0200;
        tick();
        chk("stv_last_dresp", {15'd0, data_response}, 16'd1);
        l2_resp = 1'b0; data_request = 1'b0;
        tick();

        // Flush abort with a pending store
        instruction_request = 1'b1; instruction_address = 16'h0060;
        tick();
        chk("ab_read", {15'd0, l2_read}, 16'd1);
        chk("ab_addr", l2_address, 16'h0060);
        instruction_request = 1'b0;
        data_request = 1'b1; write_enable = 1'b1; mem_address = 16'h4000;
        write_data = 16'h1111; mem_byte_enable = 2'b11;
        tick();
        chk("ab_read_held", {15'd0, l2_read}, 16'd1);
        chk("ab_addr_held", l2_address, 16'h0060);
        l2_resp = 1'b1; l2_rdata = 16'hDEAD;
        tick();
        chk("ab_no_iresp", {15'd0, instruction_response}, 16'd0);
        chk("ab_instr_hold", instr, 16'h7777);
        chk("ab_no_dresp", {15'd0, data_response}, 16'd0);
        l2_resp = 1'b0;
        tick();
        chk("ab_no_iresp2", {15'd0, instruction_response}, 16'd0);
        chk("ab_d_write", {15'd0, l2_write}, 16'd1);
        chk("ab_d_addr", l2_address, 16'h4000);
        l2_resp = 1'b1;
        tick();
        chk("ab_dresp", {15'd0, data_response}, 16'd1);
        l2_resp = 1'b0; data_request = 1'b0; write_enable = 1'b0;
        tick();

        // Async reset during D_BUSY
        data_request = 1'b1; mem_address = 16'h5000;
        tick();
        chk("rd_busy_read", {15'd0, l2_read}, 16'd1);
        reset = 1'b1;
        #1;
        chk("rd_read", {15'd0, l2_read}, 16'd0);
        chk("rd_write", {15'd0, l2_write}, 16'd0);
        chk("rd_addr", l2_address, 16'h0000);
        chk("rd_dresp", {15'd0, data_response}, 16'd0);
        chk("rd_mem_rdata", mem_rdata, 16'h0000);
        chk("rd_instr", instr, 16'h0000);
        data_request = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("rd_after_dresp", {15'd0, data_response}, 16'd0);
        chk("rd_after_read", {15'd0, l2_read}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Responder for the CPU's split instruction and data request ports. Sits between the pipeline datapath and the single word-wide L2/physical-memory port.
- Accepts level-held requests on both ports and serializes them onto one downstream transaction at a time.
- Returns a one-cycle response pulse with read data to the requesting port.
- Handles aborted instruction fetches caused by pipeline flush.

Parameters:
- MAX_DATA_STREAK, 4, maximum consecutive data grants while an instruction request waits; the next grant is then forced to instruction.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- instruction_request  in  1  fetch request, held high until instruction_response
- instruction_address  in  16  fetch word address
- instruction_response  out  1  one-cycle pulse, fetch complete
- instr  out  16  fetch data, valid while instruction_response=1
- data_request  in  1  load/store request, held until data_response
- write_enable  in  1  1=store, 0=load
- mem_address  in  16  data address
- mem_byte_enable  in  2  store byte lanes
- write_data  in  16  store data
- data_response  out  1  one-cycle pulse, data access complete
- mem_rdata  out  16  load data, valid while data_response=1
- l2_read  out  1  downstream read strobe, held until l2_resp
- l2_write  out  1  downstream write strobe, held until l2_resp
- l2_address  out  16  downstream address
- l2_wdata  out  16  downstream write data
- l2_byte_enable  out  2  downstream byte lanes
- l2_rdata  in  16  downstream read data
- l2_resp  in  1  downstream completion pulse

Behaviour:
- Reset (async): state=IDLE; every output 0; streak counter 0; abort flag 0.
- States: IDLE, I_BUSY, D_BUSY, RESP.
- IDLE:
  - If data_request=1 and (instruction_request=0 or streak<MAX_DATA_STREAK): go to D_BUSY and latch mem_address/write_enable/byte_enable/write_data.
  - Else if instruction_request=1: go to I_BUSY and latch instruction_address.
  - Grant is registered, so l2_read/l2_write assert the cycle after the request is first seen (one-cycle arbitration latency).
- I_BUSY:
  - Drive l2_read=1, l2_byte_enable=2'b11, latched address.
  - If instruction_request drops before l2_resp (flush), set abort.
  - On l2_resp: if no abort and instruction_request still high, register l2_rdata into instr and pulse instruction_response in RESP. Otherwise complete silently; no pulse.
- D_BUSY:
  - Drive l2_write=write_enable and l2_read=~write_enable, with latched wdata/byte_enable.
  - On l2_resp: register l2_rdata into mem_rdata (load) and pulse data_response in RESP.
  - data_request never aborts mid-transaction.
- RESP:
  - Exactly one cycle; the response output is 1 and the data output is valid.
  - Then return to IDLE. A request still high in IDLE the following cycle is treated as a new transaction.
- Minimum request-to-response latency is 3 cycles (grant, downstream, RESP) given a 1-cycle l2_resp.
- Downstream outputs stay stable throughout a busy state; exactly one of l2_read/l2_write is high in a busy state, and both are low otherwise.
- Streak counter:
  - Increments on each data grant while instruction_request=1.
  - Resets to 0 on any instruction grant, or on a data grant while instruction_request=0.
  - Saturates at MAX_DATA_STREAK.
- Simultaneous requests favour data (the older pipeline instruction) unless the streak limit is reached.
- instr and mem_rdata hold their last value between responses.
- Reset asserted mid-transaction: immediate return to IDLE, strobes drop, no response is issued. The downstream is expected to be reset by the same signal.

Decomposition:
- Shared package lc3b_types: lc3b_word, plus a new enum lc3b_arb_state {IDLE, I_BUSY, D_BUSY, RESP}.
- Natural sub-module: arb_req_latch, a registered capture of address/wdata/byte_enable/write_enable on grant, instantiated once and muxed by grant source.

Test Plan:
- Fetch only: instruction_request=1 at address 0x0040, l2_resp one cycle after l2_read with l2_rdata=0x1234 -> l2_address=0x0040, l2_read held, instruction_response pulses once with instr=0x1234.
- Store: data_request=1, write_enable=1, mem_address=0x8000, write_data=0xBEEF, mem_byte_enable=2'b01 -> l2_write=1 with those values latched; data_response pulses once; no l2_read.
- Simultaneous requests at address 0x0010 (instr) and 0x2000 (load data, l2_rdata=0xAAAA then 0x5555) -> data served first (mem_rdata=0xAAAA), then instruction (instr=0x5555).
- Starvation: data_request held continuously with instruction_request high, MAX_DATA_STREAK=4 -> 5th grant goes to instruction.
- Flush abort: instruction_request drops one cycle after l2_read asserts -> downstream read completes and instruction_response stays 0; a data request pending at that time is granted the cycle after RESP/IDLE.
- Async reset asserted during D_BUSY -> all outputs 0 immediately, state IDLE, no data_response.
